serial_tx: RTL
==============

# serial_tx

Parameterised serial transmitter. It accepts a parallel word through a one-cycle `en` request, then shifts it out on a single registered line `q` as a framed serial word:

- start bit 0, then WIDTH data bits, then stop bit 1;
- each bit is held for DIV clock cycles;
- the line idles high.

It is the transmit end of the bit-serial link whose receive side samples `q` through a chain of `dff` storage cells.

## Interface

Parameters:
- WIDTH, 8: data word width, ≥1
- DIV, 4: clock cycles per serial bit, ≥1
- LSB_FIRST, 1: 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- clr  in  1  reset, asynchronous, active-high
- en  in  1  transmit request; sampled only while busy=0
- d  in  WIDTH  word to send; captured on the accepting edge
- q  out  1  serial line, registered, idle high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes

## Operation

- **Reset state (while clr=1, immediately, independent of clk):**
  - q=1, busy=0, done=0, state IDLE;
  - shift register, bit counter and divider counter all 0.
- **States:** IDLE → START → DATA → STOP → IDLE.
- **IDLE:**
  - q=1, busy=0.
  - On an edge with en=1: capture d into the shift register and enter START.
  - en=0 keeps IDLE.
- **START:** q=0 for DIV cycles, then enter DATA with bit counter = 0.
- **DATA:**
  - q = current shift-register output bit, held for DIV cycles per bit.
  - LSB_FIRST=1 shifts right and outputs bit 0; LSB_FIRST=0 shifts left and outputs bit WIDTH-1.
  - After bit WIDTH-1 (counter = WIDTH-1 and divider expired), enter STOP.
- **STOP:**
  - q=1 for DIV cycles.
  - On expiry: return to IDLE, busy=0, done=1 for exactly that one cycle.
- **Request handling:**
  - en is ignored while busy=1. No queueing and no error flag.
  - Changes on d after the accepting edge do not affect the frame in flight.
- **Counter widths:**
  - divider counter is $clog2(DIV) bits, minimum 1;
  - bit counter is $clog2(WIDTH) bits, minimum 1.
  - Both wrap to 0 on reload. Neither ever exceeds its terminal value.
- **Reset mid-frame:**
  - abort immediately, with q=1 asynchronously;
  - no done pulse;
  - the next request after clr release starts a fresh frame.

## Timing

- **Edge 0** (the accepting edge, with en=1 and busy=0): from here, busy=1 and q=0. Latency from request to start bit is one edge.
- **Bit windows:**
  - start bit occupies cycles [0, DIV);
  - data bit n occupies cycles [(n+1)·DIV, (n+2)·DIV);
  - stop bit occupies cycles [(WIDTH+1)·DIV, (WIDTH+2)·DIV).
- **Edge (WIDTH+2)·DIV:** busy=0, done=1, q=1.
- **Back-to-back frames:**
  - a request is sampled earliest at edge (WIDTH+2)·DIV + 1;
  - the minimum idle-high gap between frames is therefore 1 cycle.
- **DIV=1:** one bit per cycle. The frame takes WIDTH+2 cycles plus the done cycle.
- **Glitch-free output:** all outputs are flops. q never changes between edges, except on clr assertion.

## Structure

- **Shared package `serial_pkg`:**
  - state encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - line levels: LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - The future receiver uses the same package.
- **One sub-module `bit_timer`:**
  - parameterised by DIV, with inputs clk, clr, restart;
  - outputs tick, high on the last cycle of each DIV-cycle bit window.
- **Top level:** the FSM, shift register and bit counter.

## Test plan

- **Reset:** hold clr=1 with en=1 and d=8'hFF for 3 cycles → q=1, busy=0, done=0 throughout. Release clr → IDLE.
- **Basic frame:** WIDTH=8, DIV=4, LSB_FIRST=1; d=8'hA5 with a one-cycle en pulse.
  - q bits, each 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 40 cycles; done pulses at edge 40.
- **Ignored requests:** during the 8'hA5 frame, hold en=1 and change d to 8'h3C.
  - The frame stays A5.
  - The second frame (3C: 0,0,0,1,1,1,1,0,0,1) starts at edge 41, after one idle-high cycle.
- **Reset mid-frame:** assert clr asynchronously mid data bit 3 → q=1 and busy=0 before the next edge, with no done pulse. After release, en with d=8'h0F produces a correct full frame.
- **MSB-first, DIV=1:** DIV=1, LSB_FIRST=0, d=8'h81 → q per cycle 0,1,0,0,0,0,0,0,1,1. done at edge 10.
- **Bit-window and counter-wrap check:** for d=8'h00 and d=8'hFF with DIV=3, confirm every bit window is exactly 3 cycles, and that q returns to 1 and holds after done.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial link: FSM state encoding and line levels.
// Both the transmitter and the future receiver import this package.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Request/status bundle of the serial transmitter.
// The master drives requests; the slave (the transmitter) drives the line and status.
interface serial_tx_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [WIDTH-1:0] d;
   logic             q;
   logic             busy;
   logic             done;

   modport master (output en, output d, input q, input busy, input done);
   modport slave  (input en, input d, output q, output busy, output done);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-window divider: tick marks the last clock cycle of every DIV-cycle window.
// restart holds the count at zero so the first window starts cleanly.
module bit_timer #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic restart,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Count up through one window, wrapping to zero on its last cycle.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits, stop bit, each DIV cycles.
// q, busy and done are registered from the next-state values so they change only on edges.
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIV       = 4,
   parameter int LSB_FIRST = 1
) (
   input logic        clk,
   input logic        clr,
   serial_tx_if.slave bus
);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam int OUT_IDX = (LSB_FIRST != 0) ? 0 : WIDTH - 1;

   tx_state_t        state, stateNext;
   logic [WIDTH-1:0] shreg, shNext;
   logic [BW-1:0]    bitCnt, cntNext;
   logic             qReg, qNext;
   logic             busyReg, busyNext;
   logic             doneReg, doneNext;
   logic             tick;

   bit_timer #(.DIV(DIV)) timer (
      .clk     (clk),
      .clr     (clr),
      .restart (state == IDLE),
      .tick    (tick)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state   <= IDLE;
         shreg   <= '0;
         bitCnt  <= '0;
         qReg    <= LINE_IDLE;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
      end else begin
         state   <= stateNext;
         shreg   <= shNext;
         bitCnt  <= cntNext;
         qReg    <= qNext;
         busyReg <= busyNext;
         doneReg <= doneNext;
      end
   end

   // Line level is derived from where the FSM is heading, so the registered q
   // already shows the new bit in the first cycle of each window.
   always_comb begin
      stateNext = state;
      shNext    = shreg;
      cntNext   = bitCnt;
      case (state)
         IDLE: begin
            if (bus.en) begin
               stateNext = START;
               shNext    = bus.d;
            end
         end
         START: begin
            if (tick) begin
               stateNext = DATA;
               cntNext   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bitCnt == BIT_LAST) begin
                  stateNext = STOP;
               end else begin
                  shNext  = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                  cntNext = bitCnt + BW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase

      case (stateNext)
         START:   qNext = START_BIT;
         DATA:    qNext = shNext[OUT_IDX];
         STOP:    qNext = STOP_BIT;
         default: qNext = LINE_IDLE;
      endcase
      busyNext = (stateNext != IDLE);
      doneNext = (state == STOP) && tick;
   end

   assign bus.q    = qReg;
   assign bus.busy = busyReg;
   assign bus.done = doneReg;
endmodule
